mem_io_responder: RTL and testbench

Bus-side responder for the CPU's byte-wide memory port (mem_a / mem_wr / mem_dout / mem_din / io_buffer_full), instantiated beside the CPU core at top level. It serves 128 KB of byte RAM and the memory-mapped I/O window at 0x30000: UART RX byte read, UART TX byte write with a buffering FIFO, a cycle counter read, and program stop. Read data returns on the cycle after the address; writes complete in the addressed cycle.

---
 rtl/mem_io_responder_pkg.sv | 29 ++
 rtl/mem_io_responder_if.sv | 12 +
 rtl/mem_io_responder_tx_byte_fifo.sv | 62 ++++++
 rtl/mem_io_responder.sv | 139 +++++++++++++
 tb/tb_mem_io_responder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants and types for the CPU memory-port responder.
// Holds the I/O window addresses and the mem_din source selector.
package mem_io_pkg;

  localparam logic [17:0] IO_PORT_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
  localparam logic [1:0]  IO_SEL       = 2'b11;

  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_RX   = 2'd1,
    SRC_CLK  = 2'd2,
    SRC_ZERO = 2'd3
  } din_src_e;

  // Little-endian byte lane of a 32-bit word.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte-wide memory port: the core drives address/write/data,
// the responder returns read data and TX backpressure.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (output mem_a, mem_wr, mem_dout, input mem_din, io_buffer_full);
  modport slave  (input mem_a, mem_wr, mem_dout, output mem_din, io_buffer_full);
endinterface

// File: rtl/mem_io_responder_tx_byte_fifo.sv
// Circular byte FIFO feeding the UART transmitter. A pop in the same cycle
// frees a slot, so a push into a full FIFO is accepted when it is also popped.
module tx_byte_fifo #(
  parameter int DEPTH_LOG = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               i_push,
  input  logic [7:0]         i_data,
  input  logic               i_pop,
  output logic [7:0]         o_data,
  output logic               o_empty,
  output logic               o_full,
  output logic [DEPTH_LOG:0] o_count_next
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);

  logic [7:0]           r_mem [DEPTH];
  logic [DEPTH_LOG-1:0] r_wr_ptr;
  logic [DEPTH_LOG-1:0] r_rd_ptr;
  logic [DEPTH_LOG:0]   r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign o_empty   = (r_count == {(DEPTH_LOG + 1){1'b0}});
  assign o_full    = (r_count == FULL_COUNT);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_comb begin
    o_count_next = r_count;
    if (w_do_push && !w_do_pop) begin
      o_count_next = r_count + 1'b1;
    end else if (!w_do_push && w_do_pop) begin
      o_count_next = r_count - 1'b1;
    end else begin
      o_count_next = r_count;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr <= {DEPTH_LOG{1'b0}};
      r_rd_ptr <= {DEPTH_LOG{1'b0}};
      r_count  <= {(DEPTH_LOG + 1){1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= o_count_next;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Bus-side responder for the CPU memory port: byte RAM plus the I/O window
// at 0x30000 (UART RX/TX, cycle counter snapshot, program stop).
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int    ADDR_WIDTH   = 17,
  parameter int    TX_DEPTH_LOG = 3,
  parameter int    FULL_MARGIN  = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  mem_io_responder_if.slave  bus,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               program_stop
);

  localparam int DEPTH = 1 << TX_DEPTH_LOG;

  logic [7:0]            r_ram [0:(1 << ADDR_WIDTH) - 1];
  logic [7:0]            r_din;
  logic                  r_full;
  logic                  r_stop;
  logic [31:0]           r_counter;
  logic [31:0]           r_snap;

  logic [17:0]           w_addr;
  logic [ADDR_WIDTH-1:0] w_ram_idx;
  logic                  w_io;
  logic                  w_clk_win;
  logic                  w_rx_pop;
  logic                  w_snap_take;
  logic                  w_char_push;
  logic                  w_stop_wr;
  logic                  w_tx_push;
  logic [7:0]            w_tx_wdata;
  logic                  w_tx_pop;
  logic                  w_ram_we;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [TX_DEPTH_LOG:0] w_count_next;
  logic                  w_full_next;
  logic [31:0]           w_snap_next;
  din_src_e              w_src;
  logic [7:0]            w_din_next;
  logic                  w_unused_addr_hi;

  assign w_addr           = bus.mem_a[17:0];
  assign w_ram_idx        = bus.mem_a[ADDR_WIDTH-1:0];
  assign w_unused_addr_hi = ^bus.mem_a[31:18];
  assign w_io             = (w_addr[17:16] == IO_SEL);
  assign w_clk_win        = w_io && (w_addr[17:2] == IO_CLK_ADDR[17:2]);

  // Side effects all require rdy_in; reads of RAM do not.
  assign w_rx_pop    = rdy_in & ~bus.mem_wr & w_io & (w_addr == IO_PORT_ADDR) & rx_valid;
  assign w_snap_take = rdy_in & ~bus.mem_wr & w_io & (w_addr == IO_CLK_ADDR);
  assign w_char_push = rdy_in & bus.mem_wr & w_io & (w_addr == IO_PORT_ADDR) & (bus.mem_dout != 8'h00);
  assign w_stop_wr   = rdy_in & bus.mem_wr & w_io & (w_addr == IO_CLK_ADDR);
  assign w_ram_we    = rdy_in & bus.mem_wr & ~w_io;
  assign w_tx_push   = w_char_push | w_stop_wr;
  assign w_tx_wdata  = w_stop_wr ? 8'h00 : bus.mem_dout;
  assign w_tx_pop    = tx_valid & tx_ready;
  assign w_snap_next = w_snap_take ? r_counter : r_snap;
  assign w_full_next = (DEPTH - int'(w_count_next)) <= FULL_MARGIN;

  assign rx_ready           = w_rx_pop;
  assign tx_valid           = ~w_fifo_empty;
  assign bus.mem_din        = r_din;
  assign bus.io_buffer_full = r_full;
  assign program_stop       = r_stop;

  tx_byte_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .i_push       (w_tx_push),
    .i_data       (w_tx_wdata),
    .i_pop        (w_tx_pop),
    .o_data       (tx_data),
    .o_empty      (w_fifo_empty),
    .o_full       (w_fifo_full),
    .o_count_next (w_count_next)
  );

  always_comb begin
    w_src = SRC_ZERO;
    if (bus.mem_wr) begin
      w_src = SRC_ZERO;
    end else if (!w_io) begin
      w_src = SRC_RAM;
    end else if (w_addr == IO_PORT_ADDR) begin
      w_src = w_rx_pop ? SRC_RX : SRC_ZERO;
    end else if (w_clk_win) begin
      w_src = SRC_CLK;
    end else begin
      w_src = SRC_ZERO;
    end
  end

  always_comb begin
    w_din_next = 8'h00;
    case (w_src)
      SRC_RAM:  w_din_next = r_ram[w_ram_idx];
      SRC_RX:   w_din_next = rx_data;
      SRC_CLK:  w_din_next = byte_sel(w_snap_next, w_addr[1:0]);
      SRC_ZERO: w_din_next = 8'h00;
      default:  w_din_next = 8'h00;
    endcase
  end

  // RAM contents survive reset.
  always_ff @(posedge clk_in) begin
    if (w_ram_we) begin
      r_ram[w_ram_idx] <= bus.mem_dout;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_din     <= 8'h00;
      r_full    <= 1'b0;
      r_stop    <= 1'b0;
      r_counter <= 32'd0;
      r_snap    <= 32'd0;
    end else begin
      r_din  <= w_din_next;
      r_full <= w_full_next;
      r_snap <= w_snap_next;
      if (w_stop_wr) r_stop <= 1'b1;
      if (rdy_in)    r_counter <= r_counter + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, UART RX/TX, counter snapshot,
// rdy_in gating, program stop and mid-run reset.
module tb_mem_io_responder;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       rdy_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       program_stop;
  int         n_checks = 0;
  int         n_fail   = 0;

  mem_io_responder_if bus ();

  mem_io_responder dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .bus          (bus.slave),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .program_stop (program_stop)
  );

  always #5 clk_in = ~clk_in;

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    bus.mem_a    = a;
    bus.mem_wr   = wr;
    bus.mem_dout = d;
  endtask

  task automatic test_reset;
    rst_in = 1'b1; rdy_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    drive(32'h0003_0004, 1'b1, 8'h33);
    repeat (2) @(negedge clk_in);
    n_checks++; if (bus.mem_din !== 8'h00) begin n_fail++; $display("FAIL reset_din: got %h exp 00", bus.mem_din); end
    n_checks++; if (bus.io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b exp 0", bus.io_buffer_full); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b exp 0", tx_valid); end
    n_checks++; if (program_stop !== 1'b0) begin n_fail++; $display("FAIL reset_stop: got %b exp 0", program_stop); end
    drive(32'h0000_0010, 1'b0, 8'h00);
    rst_in = 1'b0;
  endtask

  task automatic test_ram;
    drive(32'h0000_0010, 1'b1, 8'hA5);
    @(negedge clk_in);
    n_checks++; if (bus.mem_din !== 8'h00) begin n_fail++; $display("FAIL ram_wr_resp0: got %h exp 00", bus.mem_din); end
    drive(32'h0001_FFFF, 1'b1, 8'h3C);
    @(negedge clk_in);
    n_checks++; if (bus.mem_din !== 8'h00) begin n_fail++; $display("FAIL ram_wr_resp1: got %h exp 00", bus.mem_din); end
    drive(32'h0000_0010, 1'b0, 8'h00);
    @(negedge clk_in);
    n_checks++; if (bus.mem_din !== 8'hA5) begin n_fail++; $display("FAIL ram_rd_10: got %h exp a5", bus.mem_din); end
    rdy_in = 1'b0;
    drive(32'h0001_FFFF, 1'b0, 8'h00);
    @(negedge clk_in);
    n_checks++; if (bus.mem_din !== 8'h3C) begin n_fail++; $display("FAIL ram_rd_top_rdy0: got %h exp 3c", bus.mem_din); end
    rdy_in = 1'b1;
    drive(32'hFFFC_0010, 1'b0, 8'h00);
    @(negedge clk_in);
    n_checks++; if (bus.mem_din !== 8'hA5) begin n_fail++; $display("FAIL ram_rd_hi_bits: got %h exp a5", bus.mem_din); end
  endtask

  task automatic test_rx;
    rx_valid = 1'b1; rx_data = 8'h41;
    drive(32'h0003_0000, 1'b0, 8'h00);
    #1;
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_pulse: got %b exp 1", rx_ready); end
    @(negedge clk_in);
    n_checks++; if (bus.mem_din !== 8'h41) begin n_fail++; $display("FAIL rx_data: got %h exp 41", bus.mem_din); end
    drive(32'h0000_0010, 1'b0, 8'h00);
    #1;
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready_drop: got %b exp 0", rx_ready); end
    @(negedge clk_in);
    rx_valid = 1'b0;
    drive(32'h0003_0000, 1'b0, 8'h00);
    #1;
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready_novalid: got %b exp 0", rx_ready); end
    @(negedge clk_in);
    n_checks++; if (bus.mem_din !== 8'h00) begin n_fail++; $display("FAIL rx_empty_din: got %h exp 00", bus.mem_din); end
    rdy_in = 1'b0; rx_valid = 1'b1;
    #1;
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready_rdy0: got %b exp 0", rx_ready); end
    rdy_in = 1'b1;
    drive(32'h0000_0010, 1'b0, 8'h00);
    @(negedge clk_in);
    drive(32'h0003_0001, 1'b0, 8'h00);
    #1;
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready_other_io: got %b exp 0", rx_ready); end
    @(negedge clk_in);
    n_checks++; if (bus.mem_din !== 8'h00) begin n_fail++; $display("FAIL other_io_din: got %h exp 00", bus.mem_din); end
    rx_valid = 1'b0;
  endtask

  task automatic test_tx_fifo;
    logic [7:0] wr_bytes [10] = '{8'h61, 8'h00, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
    logic       exp_full [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] drain [9]     = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h70};
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(32'h0003_0000, 1'b1, wr_bytes[i]);
      @(negedge clk_in);
      n_checks++; if (bus.io_buffer_full !== exp_full[i]) begin n_fail++; $display("FAIL tx_full_step%0d: got %b exp %b", i, bus.io_buffer_full, exp_full[i]); end
    end
    n_checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h61}) begin n_fail++; $display("FAIL tx_head_hold: got %b/%h exp 1/61", tx_valid, tx_data); end
    for (int i = 0; i < 9; i++) begin
      n_checks++; if ({tx_valid, tx_data} !== {1'b1, drain[i]}) begin n_fail++; $display("FAIL tx_drain%0d: got %b/%h exp 1/%h", i, tx_valid, tx_data, drain[i]); end
      if (i == 0) drive(32'h0003_0000, 1'b1, 8'h70);
      else        drive(32'h0000_0010, 1'b0, 8'h00);
      tx_ready = 1'b1;
      @(negedge clk_in);
      if (i == 0) begin
        n_checks++; if (bus.io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL tx_full_pushpop: got %b exp 1", bus.io_buffer_full); end
      end
    end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained: got %b exp 0", tx_valid); end
    n_checks++; if (bus.io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL tx_full_clear: got %b exp 0", bus.io_buffer_full); end
    drive(32'h0003_0000, 1'b1, 8'h71);
    @(negedge clk_in);
    n_checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h71}) begin n_fail++; $display("FAIL tx_empty_pushpop: got %b/%h exp 1/71", tx_valid, tx_data); end
    drive(32'h0000_0010, 1'b0, 8'h00);
    @(negedge clk_in);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_single_pop: got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_counter;
    logic [7:0] exp_snap [4] = '{8'h64, 8'h00, 8'h00, 8'h00};
    rst_in = 1'b1;
    drive(32'h0000_0010, 1'b0, 8'h00);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (100) @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      drive(32'h0003_0004 + 32'(i), 1'b0, 8'h00);
      @(negedge clk_in);
      n_checks++; if (bus.mem_din !== exp_snap[i]) begin n_fail++; $display("FAIL snap_byte%0d: got %h exp %h", i, bus.mem_din, exp_snap[i]); end
    end
    drive(32'h0003_0004, 1'b0, 8'h00);
    @(negedge clk_in);
    n_checks++; if (bus.mem_din !== 8'h68) begin n_fail++; $display("FAIL snap_second: got %h exp 68", bus.mem_din); end
  endtask

  task automatic test_rdy_low;
    rdy_in = 1'b0;
    drive(32'h0003_0000, 1'b1, 8'h55);
    repeat (10) @(negedge clk_in);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rdy0_no_push: got %b exp 0", tx_valid); end
    n_checks++; if (bus.mem_din !== 8'h00) begin n_fail++; $display("FAIL rdy0_wr_din: got %h exp 00", bus.mem_din); end
    rdy_in = 1'b1;
    drive(32'h0003_0004, 1'b0, 8'h00);
    @(negedge clk_in);
    n_checks++; if (bus.mem_din !== 8'h69) begin n_fail++; $display("FAIL rdy0_counter_frozen: got %h exp 69", bus.mem_din); end
  endtask

  task automatic test_stop;
    tx_ready = 1'b0;
    drive(32'h0003_0004, 1'b1, 8'hEE);
    @(negedge clk_in);
    n_checks++; if (program_stop !== 1'b1) begin n_fail++; $display("FAIL stop_set: got %b exp 1", program_stop); end
    n_checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL stop_nul: got %b/%h exp 1/00", tx_valid, tx_data); end
    drive(32'h0003_0000, 1'b1, 8'h7A);
    @(negedge clk_in);
    drive(32'h0000_0010, 1'b0, 8'h00);
    repeat (5) @(negedge clk_in);
    n_checks++; if (program_stop !== 1'b1) begin n_fail++; $display("FAIL stop_sticky: got %b exp 1", program_stop); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL stop_nul_hold: got %h exp 00", tx_data); end
    n_checks++; if (bus.mem_din !== 8'hA5) begin n_fail++; $display("FAIL pre_reset_din: got %h exp a5", bus.mem_din); end
    rst_in = 1'b1;
    @(negedge clk_in);
    n_checks++; if (bus.mem_din !== 8'h00) begin n_fail++; $display("FAIL midrst_din: got %h exp 00", bus.mem_din); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flush: got %b exp 0", tx_valid); end
    n_checks++; if (program_stop !== 1'b0) begin n_fail++; $display("FAIL midrst_stop: got %b exp 0", program_stop); end
    rst_in = 1'b0;
    @(negedge clk_in);
    n_checks++; if (bus.mem_din !== 8'hA5) begin n_fail++; $display("FAIL ram_kept: got %h exp a5", bus.mem_din); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ram();
    test_rx();
    test_tx_fifo();
    test_counter();
    test_rdy_low();
    test_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
